// File: rtl/act_approx_pipe_if.sv
// Sample/result bus of act_approx_pipe: shared enable, valid and mode with packed lane data.
interface act_approx_pipe_if #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4
);
    logic                    ENABLE;
    logic                    IN_VALID;
    logic [1:0]              MODE;
    logic [LANES*DATA_W-1:0] IN;
    logic                    OUT_VALID;
    logic [LANES*DATA_W-1:0] OUT;
    logic [15:0]             SAT_COUNT;

    modport master (output ENABLE, IN_VALID, MODE, IN, input  OUT_VALID, OUT, SAT_COUNT);
    modport slave  (input  ENABLE, IN_VALID, MODE, IN, output OUT_VALID, OUT, SAT_COUNT);
endinterface

// File: rtl/act_approx_pipe.sv
// 3-stage multi-lane activation unit: PLAN sigmoid, tanh, ReLU, identity.
// Define ACT_SAT_COUNT_EN to build the saturating SAT_COUNT event counter.
module act_approx_pipe #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int LANES  = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    act_approx_pipe_if.slave bus
);
    localparam int IW = DATA_W + 1;
    typedef logic signed [DATA_W-1:0] samp_t;
    typedef logic signed [IW-1:0]     wide_t;

    localparam samp_t S_MAX = samp_t'({1'b0, {(DATA_W-1){1'b1}}});
    localparam samp_t S_MIN = samp_t'({1'b1, {(DATA_W-1){1'b0}}});
    localparam wide_t ONE   = wide_t'(1)  <<< FRAC_W;
    localparam wide_t A_SAT = wide_t'(5)  <<< FRAC_W;        // 5.0
    localparam wide_t A_MID = wide_t'(19) <<< (FRAC_W - 3);  // 2.375
    localparam wide_t C_HI  = wide_t'(27) <<< (FRAC_W - 5);  // 0.84375
    localparam wide_t C_MID = wide_t'(5)  <<< (FRAC_W - 3);  // 0.625
    localparam wide_t C_LO  = wide_t'(1)  <<< (FRAC_W - 1);  // 0.5

    function automatic samp_t sat_double(input samp_t x);
        wide_t d;
        d = wide_t'(x) <<< 1;
        if (d > wide_t'(S_MAX))      return S_MAX;
        else if (d < wide_t'(S_MIN)) return S_MIN;
        else                         return samp_t'(d);
    endfunction

    function automatic wide_t abs_sat(input samp_t x);
        wide_t w;
        w = wide_t'(x);
        if (w[IW-1]) w = -w;
        return (w > wide_t'(S_MAX)) ? wide_t'(S_MAX) : w;
    endfunction

    function automatic wide_t plan_seg(input wide_t a);
        if (a >= A_SAT)      return ONE;
        else if (a >= A_MID) return (a >> 5) + C_HI;
        else if (a >= ONE)   return (a >> 3) + C_MID;
        else                 return (a >> 2) + C_LO;
    endfunction

    function automatic samp_t mode_sel(input logic [1:0] mode, input samp_t x,
                                       input wide_t y, input logic neg);
        wide_t yf;
        wide_t r;
        yf = neg ? (ONE - y) : y;
        case (mode)
            2'd0:    r = yf;
            2'd1:    r = (yf <<< 1) - ONE;
            2'd2:    r = x[DATA_W-1] ? '0 : wide_t'(x);
            default: r = wide_t'(x);
        endcase
        return samp_t'(r);
    endfunction

    samp_t            x_in   [LANES];
    wide_t            a_in   [LANES];
    samp_t            x_p0   [LANES];
    wide_t            a_p0   [LANES];
    logic [LANES-1:0] neg_p0;
    logic [1:0]       mode_p0;
    logic             vld_p0;
    wide_t            y_c    [LANES];
    samp_t            x_p1   [LANES];
    wide_t            y_p1   [LANES];
    logic [LANES-1:0] neg_p1;
    logic [1:0]       mode_p1;
    logic             vld_p1;
    samp_t            r_c    [LANES];
    samp_t            out_p2 [LANES];
    logic             vld_p2;
    logic [LANES*DATA_W-1:0] out_flat;

    // Stage 1: tanh pre-doubling, magnitude and sign
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            x_in[i] = samp_t'(bus.IN[i*DATA_W +: DATA_W]);
            a_in[i] = abs_sat((bus.MODE == 2'd1) ? sat_double(x_in[i]) : x_in[i]);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vld_p0  <= 1'b0;
            mode_p0 <= '0;
            neg_p0  <= '0;
            for (int i = 0; i < LANES; i++) begin
                x_p0[i] <= '0;
                a_p0[i] <= '0;
            end
        end else if (bus.ENABLE) begin
            vld_p0  <= bus.IN_VALID;
            mode_p0 <= bus.MODE;
            for (int i = 0; i < LANES; i++) begin
                x_p0[i]   <= x_in[i];
                a_p0[i]   <= a_in[i];
                neg_p0[i] <= x_in[i][DATA_W-1];
            end
        end
    end

    // Stage 2: PLAN segment evaluation on the magnitude
    always_comb begin
        for (int i = 0; i < LANES; i++) y_c[i] = plan_seg(a_p0[i]);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vld_p1  <= 1'b0;
            mode_p1 <= '0;
            neg_p1  <= '0;
            for (int i = 0; i < LANES; i++) begin
                x_p1[i] <= '0;
                y_p1[i] <= '0;
            end
        end else if (bus.ENABLE) begin
            vld_p1  <= vld_p0;
            mode_p1 <= mode_p0;
            neg_p1  <= neg_p0;
            for (int i = 0; i < LANES; i++) begin
                x_p1[i] <= x_p0[i];
                y_p1[i] <= y_c[i];
            end
        end
    end

    // Stage 3: symmetry fold and mode select; OUT holds across bubbles
    always_comb begin
        for (int i = 0; i < LANES; i++) r_c[i] = mode_sel(mode_p1, x_p1[i], y_p1[i], neg_p1[i]);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vld_p2 <= 1'b0;
            for (int i = 0; i < LANES; i++) out_p2[i] <= '0;
        end else if (bus.ENABLE) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                for (int i = 0; i < LANES; i++) out_p2[i] <= r_c[i];
            end
        end
    end

    always_comb begin
        out_flat = '0;
        for (int i = 0; i < LANES; i++) out_flat[i*DATA_W +: DATA_W] = out_p2[i];
    end

    assign bus.OUT       = out_flat;
    assign bus.OUT_VALID = vld_p2;

`ifdef ACT_SAT_COUNT_EN
    function automatic logic [15:0] sat_add16(input logic [15:0] cnt, input logic [15:0] inc);
        logic [16:0] s;
        s = {1'b0, cnt} + {1'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [15:0] sat_cnt;
    logic [15:0] sat_hits;

    always_comb begin
        sat_hits = '0;
        for (int i = 0; i < LANES; i++) sat_hits = sat_hits + {15'd0, (a_p0[i] >= A_SAT)};
    end

    // Only sigmoid/tanh samples (MODE[1]==0) go through the PLAN path
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            sat_cnt <= '0;
        else if (bus.ENABLE && vld_p0 && !mode_p0[1])
            sat_cnt <= sat_add16(sat_cnt, sat_hits);
    end

    assign bus.SAT_COUNT = sat_cnt;
`else
    assign bus.SAT_COUNT = 16'h0000;
`endif
endmodule

// File: tb/tb_act_approx_pipe.sv
// Table-driven scoreboard bench for act_approx_pipe (DATA_W=16, FRAC_W=8, LANES=4).
module tb_act_approx_pipe;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;
    localparam int LANES  = 4;
    localparam int VW     = LANES * DATA_W;
`ifdef ACT_SAT_COUNT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0]    mode;
        logic [VW-1:0] x;
        logic [VW-1:0] y;
        int            hits;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET_N;

    act_approx_pipe_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();

    act_approx_pipe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .LANES(LANES)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    vec_t          tbl [10];
    logic [VW-1:0] exp_q [$];
    logic [VW-1:0] last_out = '0;
    logic          m0 = 1'b0, m1 = 1'b0, m2 = 1'b0;
    int            n_checks = 0;
    int            n_pass   = 0;
    int            exp_sat  = 0;

    function automatic logic [VW-1:0] pk(input logic [15:0] l0, input logic [15:0] l1,
                                         input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, req);
    endtask

    task automatic chk_sat(input string nm);
        chk(nm, VW'(bus.SAT_COUNT), SAT_EN ? VW'(exp_sat) : '0);
    endtask

    // Called at a falling edge; applies inputs for the next rising edge.
    task automatic drive(input logic en, input logic iv, input logic [1:0] md,
                         input logic [VW-1:0] x, input logic [VW-1:0] y, input int hits);
        bus.ENABLE   = en;
        bus.IN_VALID = iv;
        bus.MODE     = md;
        bus.IN       = x;
        if (en && iv) begin
            exp_q.push_back(y);
            if (!md[1]) exp_sat = (exp_sat + hits > 65535) ? 65535 : exp_sat + hits;
        end
        @(negedge CLK);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || m0 || m1 || m2) && k < budget) begin
            drive(1'b1, 1'b0, 2'd0, '0, '0, 0);
            k++;
        end
        chk("drain_left", VW'(exp_q.size()), '0);
    endtask

    // Reference valid pipeline plus scoreboard pop on every rising edge
    always @(posedge CLK) begin : mon
        logic en;
        logic iv;
        logic rn;
        logic [VW-1:0] e;
        en = bus.ENABLE;
        iv = bus.IN_VALID;
        rn = RESET_N;
        if (!rn) begin
            m0 = 1'b0; m1 = 1'b0; m2 = 1'b0;
        end else if (en) begin
            m2 = m1; m1 = m0; m0 = iv;
        end
        #1;
        chk("out_valid", VW'(bus.OUT_VALID), VW'(m2));
        if (rn && en && m2) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_underflow: got OUT %h, required no output", bus.OUT);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", bus.OUT, e);
                last_out = e;
            end
        end else begin
            chk("out_hold", bus.OUT, last_out);
        end
    end

    initial begin
        RESET_N      = 1'b0;
        bus.ENABLE   = 1'b0;
        bus.IN_VALID = 1'b0;
        bus.MODE     = 2'd0;
        bus.IN       = '0;

        tbl[0] = '{2'd0, pk(16'h0700, 16'h0230, 16'h0080, 16'hFF80), pk(16'h0100, 16'h00E6, 16'h00A0, 16'h0060), 1};
        tbl[1] = '{2'd0, pk(16'h8000, 16'h7FFF, 16'h0648, 16'h0000), pk(16'h0000, 16'h0100, 16'h0100, 16'h0080), 3};
        tbl[2] = '{2'd1, pk(16'h0080, 16'hFF80, 16'h0000, 16'h7FFF), pk(16'h0080, 16'hFF80, 16'h0000, 16'h0100), 1};
        tbl[3] = '{2'd2, pk(16'h0080, 16'hFF80, 16'h0000, 16'h7FFF), pk(16'h0080, 16'h0000, 16'h0000, 16'h7FFF), 0};
        tbl[4] = '{2'd3, pk(16'h8000, 16'h7FFF, 16'h1234, 16'hFEDC), pk(16'h8000, 16'h7FFF, 16'h1234, 16'hFEDC), 0};
        tbl[5] = '{2'd0, pk(16'h0100, 16'h00FF, 16'h04FF, 16'h0500), pk(16'h00C0, 16'h00BF, 16'h00FF, 16'h0100), 1};
        tbl[6] = '{2'd0, pk(16'h0260, 16'h025F, 16'hFB00, 16'hFF00), pk(16'h00EB, 16'h00EB, 16'h0000, 16'h0040), 1};
        tbl[7] = '{2'd1, pk(16'h0280, 16'hFD80, 16'h4000, 16'h8000), pk(16'h0100, 16'hFF00, 16'h0100, 16'hFF00), 4};
        tbl[8] = '{2'd1, pk(16'h0040, 16'h0100, 16'hFF00, 16'h0001), pk(16'h0040, 16'h00C0, 16'hFF40, 16'h0000), 0};
        tbl[9] = '{2'd2, pk(16'h8000, 16'h0001, 16'hFFFF, 16'h7FFF), pk(16'h0000, 16'h0001, 16'h0000, 16'h7FFF), 0};

        repeat (2) @(negedge CLK);
        chk("reset_out", bus.OUT, '0);
        chk("reset_out_valid", VW'(bus.OUT_VALID), '0);
        chk("reset_sat_count", VW'(bus.SAT_COUNT), '0);
        RESET_N = 1'b1;
        @(negedge CLK);

        // Back-to-back table, includes modes 0,1,2,3 on consecutive cycles
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, tbl[i].mode, tbl[i].x, tbl[i].y, tbl[i].hits);
        drain(20);
        chk_sat("sat_count_table");

        // Bubbles between valid vectors
        drive(1'b1, 1'b1, tbl[5].mode, tbl[5].x, tbl[5].y, tbl[5].hits);
        drive(1'b1, 1'b0, 2'd0, '0, '0, 0);
        drive(1'b1, 1'b1, tbl[6].mode, tbl[6].x, tbl[6].y, tbl[6].hits);
        drain(20);

        // Stall with two samples in flight; valid input during stall must be ignored
        drive(1'b1, 1'b1, tbl[0].mode, tbl[0].x, tbl[0].y, tbl[0].hits);
        drive(1'b1, 1'b1, tbl[2].mode, tbl[2].x, tbl[2].y, tbl[2].hits);
        repeat (5) drive(1'b0, 1'b1, 2'd0, {LANES{16'h7FFF}}, '0, 0);
        drain(20);
        chk_sat("sat_count_stall");

        // Asynchronous reset between edges with the pipe full
        drive(1'b1, 1'b1, tbl[1].mode, tbl[1].x, tbl[1].y, tbl[1].hits);
        drive(1'b1, 1'b1, tbl[7].mode, tbl[7].x, tbl[7].y, tbl[7].hits);
        drive(1'b1, 1'b1, tbl[0].mode, tbl[0].x, tbl[0].y, tbl[0].hits);
        bus.IN_VALID = 1'b1;
        bus.MODE     = tbl[2].mode;
        bus.IN       = tbl[2].x;
        #2;
        RESET_N = 1'b0;
        #1;
        chk("midrst_out", bus.OUT, '0);
        chk("midrst_out_valid", VW'(bus.OUT_VALID), '0);
        chk("midrst_sat_count", VW'(bus.SAT_COUNT), '0);
        exp_q.delete();
        m0 = 1'b0; m1 = 1'b0; m2 = 1'b0;
        last_out = '0;
        exp_sat  = 0;
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (6) drive(1'b1, 1'b0, 2'd0, '0, '0, 0);
        drive(1'b1, 1'b1, tbl[8].mode, tbl[8].x, tbl[8].y, tbl[8].hits);
        drive(1'b1, 1'b1, tbl[6].mode, tbl[6].x, tbl[6].y, tbl[6].hits);
        drain(20);
        chk_sat("sat_count_after_reset");

        // Long run of fully saturating lanes drives the counter past 16'hFFFF
        repeat (16400) drive(1'b1, 1'b1, 2'd0, {LANES{16'h7FFF}}, {LANES{16'h0100}}, LANES);
        drain(20);
        chk_sat("sat_count_ceiling");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/act_approx_pipe.md
Name: act_approx_pipe

Overview:
- Pipelined, multi-lane, multi-mode activation unit; successor to the combinational sigmoid approximator.
- Sits between the conv/FC accumulator output and the feature-map writeback in the CNN datapath.
- Implements a shift-add piecewise-linear (PLAN) sigmoid, tanh derived from it, ReLU, and identity.
- LANES samples per cycle; fixed 3-cycle latency; global ENABLE stalls the whole pipe.

Parameters:
- DATA_W, 16, sample width; signed two's complement, Q(DATA_W-FRAC_W).FRAC_W.
- FRAC_W, 8, fraction bits; legal range 5..DATA_W-4; 1.0 = 2^FRAC_W.
- LANES, 4, samples processed in parallel; all lanes share MODE and valid.

Ports:
- CLK  input  1  clock, rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- ENABLE  input  1  pipeline advance; 0 freezes every stage register.
- IN_VALID  input  1  IN carries a valid sample vector this cycle.
- MODE  input  2  0=sigmoid, 1=tanh, 2=ReLU, 3=identity; captured with the sample.
- IN  input  LANES*DATA_W  packed samples; lane i = IN[i*DATA_W +: DATA_W].
- OUT_VALID  output  1  OUT holds a valid result.
- OUT  output  LANES*DATA_W  packed results, same format and lane order as IN.
- SAT_COUNT  output  16  saturation event count (optional feature; otherwise 0).

Behaviour:
- Reset (async, RESET_N=0): all stage registers, OUT, OUT_VALID, and SAT_COUNT clear to 0 immediately. Reset mid-operation discards in-flight samples; no result is produced for them.
- Advance: every stage register loads only when ENABLE=1. With ENABLE=0, OUT, OUT_VALID, and all internal state hold. IN_VALID is ignored while ENABLE=0.
- Latency: a sample accepted at edge N (ENABLE=1, IN_VALID=1) appears at OUT with OUT_VALID=1 after edge N+2, counting only enabled edges. Throughput is one vector per enabled cycle.
- Bubbles: IN_VALID=0 propagates as OUT_VALID=0. OUT keeps its previous value on bubbles (no clearing).
- Stage 1: register the sample, MODE, and valid.
  - For tanh, form x' = 2x with signed saturation to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; otherwise x' = x.
  - Compute a = |x'|; |most-negative| saturates to the max positive value. Register the sign.
- Stage 2: PLAN segment on a, with constants scaled by 2^FRAC_W.
  - a >= 5.0: y = 1.0.
  - 2.375 <= a < 5.0: y = (a>>5) + 0.84375.
  - 1.0 <= a < 2.375: y = (a>>3) + 0.625.
  - a < 1.0: y = (a>>2) + 0.5.
  - Shifts are logical on the non-negative a, truncating.
- Stage 3: symmetry and mode selection.
  - Sigmoid: y_final = y if the sign is positive, else 1.0 - y. Result lies in [0, 1.0].
  - Tanh: 2*y_final - 1.0, a signed result in [-1.0, 1.0].
  - ReLU: x if x >= 0, else 0.
  - Identity: x unchanged.
  - In ReLU and identity modes the PLAN path result is unused.
- Lanes are independent arithmetic copies; there is no cross-lane interaction.
- Width rules:
  - All intermediates are DATA_W+1 bits.
  - Final results always fit in DATA_W, so no output saturation is needed.
  - Segment boundaries are exact at FRAC_W>=5.

Optional Feature:
- Macro ACT_SAT_COUNT_EN.
- Defined:
  - SAT_COUNT increments by the number of lanes whose a >= 5.0 in an accepted sigmoid/tanh sample. Counting happens at stage 2 on enabled edges.
  - The count saturates at 16'hFFFF and does not wrap.
  - It is cleared only by reset.
- Undefined: SAT_COUNT is tied to 16'h0000 and no counter logic is instantiated.

Test Plan (DATA_W=16, FRAC_W=8, LANES=4):
- Sigmoid, IN lanes = {0x0700, 0x0230, 0x0080, 0xFF80} -> OUT {0x0100, 0x00E6, 0x00A0, 0x0060}, three enabled cycles after acceptance.
- Sigmoid extremes: lanes {0x8000, 0x7FFF, 0x0648, 0x0000} -> {0x0000, 0x0100, 0x0100, 0x0080}. With ACT_SAT_COUNT_EN defined, SAT_COUNT goes 0 -> 3.
- Tanh, lanes {0x0080, 0xFF80, 0x0000, 0x7FFF} -> {0x0080, 0xFF80, 0x0000, 0x0100}. ReLU on the same vector -> {0x0080, 0x0000, 0x0000, 0x7FFF}.
- Back-to-back vectors in modes 0, 1, 2, 3 on consecutive cycles -> results emerge on consecutive cycles, each processed with its own MODE.
- ENABLE=0 held for 5 cycles with 2 samples in flight -> OUT and OUT_VALID frozen. After ENABLE returns to 1, both results appear in order with no loss or duplication.
- Assert RESET_N=0 asynchronously between edges while the pipe is full -> OUT, OUT_VALID, and SAT_COUNT go to 0 immediately. After release, no stale result appears.
